shift_unit_seq_16: RTL

//   Multi-cycle 16-bit shifter for the execute stage. Shifts one bit position per clock.
//   Its registered result drives the second data input of the 16-bit 2:1 writeback result mux.
//   The shifter's done flag steers that mux's control input for the writeback cycle.

---
 rtl/shift_unit_seq_16_if.sv | 33 +++
 rtl/shift_unit_seq_16.sv | 103 ++++++++++
 2 files changed

// File: rtl/shift_unit_seq_16_if.sv
// Request/response bundle between the execute-stage control FSM and the
// multi-cycle shifter.
//   start   : request a shift (taken only while ready=1)
//   op      : 00=SLL 01=SRL 10=SRA 11=ROL
//   operand : value to shift
//   shamt   : shift amount 0..2**SHW-1
//   ready   : shifter idle, start will be accepted this cycle
//   done    : one-cycle pulse, result final
//   result  : shifted value, held from done until the next accept
interface shift_unit_seq_16_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 4
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand;
    logic [SHW-1:0]   shamt;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;

    // Requester side (control FSM)
    modport master (
        output start, op, operand, shamt,
        input  ready, done, result
    );

    // Shifter side
    modport slave (
        input  start, op, operand, shamt,
        output ready, done, result
    );
endinterface

// File: rtl/shift_unit_seq_16.sv
// Multi-cycle 16-bit shifter, one bit position per clock.
// Supports SLL, SRL, SRA and ROL behind a start/ready/done handshake; the
// registered result feeds the writeback mux and done steers its select.
//   clk : system clock, rising edge
//   rst : synchronous active-low reset
//   bus : shift_unit_seq_16_if slave modport (start/op/operand/shamt in,
//         ready/done/result out); all outputs come straight from flops.
module shift_unit_seq_16 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_unit_seq_16_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_SLL = 2'd0,
        OP_SRL = 2'd1,
        OP_SRA = 2'd2,
        OP_ROL = 2'd3
    } op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_SLL;
            result_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            result_q <= result_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        result_d = result_q;
        count_d  = count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d     = op_e'(bus.op);
                    result_d = bus.operand;
                    count_d  = bus.shamt;
                    state_d  = (bus.shamt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                unique case (op_q)
                    OP_SLL: result_d = {result_q[WIDTH-2:0], 1'b0};
                    OP_SRL: result_d = {1'b0, result_q[WIDTH-1:1]};
                    OP_SRA: result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
                    OP_ROL: result_d = {result_q[WIDTH-2:0], result_q[WIDTH-1]};
                    default: result_d = result_q;
                endcase
                count_d = count_q - SHW'(1);
                // Final shift happens on the same edge that leaves SHIFT
                if (count_q == SHW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they appear registered
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    assign bus.ready  = ready_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule
